// File: rtl/logic_pkg.sv
// Shared definitions for the Logic stage and its neighbours: sweep FSM state
// encodings and width helpers for address and entry fields.
package logic_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ADDR   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // A one-value range still needs a one-bit field, so never return zero.
    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int entry_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/logic_result_streamer.sv
// Sweeps a run of addresses into the Logic stage, snapshots each final_result
// vector and streams its entries out one beat at a time over valid/ready.
module logic_result_streamer
    import logic_pkg::*;
#(
    parameter int SIZE = 16,
    parameter int K    = 8,
    localparam int AW  = addr_width(SIZE),
    localparam int IW  = entry_width(K)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      start_addr,
    input  logic [AW:0]        addr_count,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      logic_addr,
    input  logic [SIZE*IW-1:0] logic_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [AW-1:0]      out_addr,
    output logic [AW-1:0]      out_idx,
    output logic [IW-1:0]      out_data,
    output logic               out_last
);

    localparam logic [AW-1:0] LAST_IDX = AW'(SIZE - 1);
    localparam logic [AW:0]   SIZE_CNT = (AW + 1)'(SIZE);
    localparam logic [AW:0]   ONE_CNT  = (AW + 1)'(1);

    logic [1:0]         state;
    logic [AW-1:0]      cur_addr;
    logic [AW-1:0]      idx;
    logic [AW:0]        remaining;
    logic [SIZE*IW-1:0] shadow;

    logic [AW:0]        clamped_count;
    logic [AW-1:0]      next_addr;
    logic               handshake;
    logic               last_entry;

    assign clamped_count = (addr_count > SIZE_CNT) ? SIZE_CNT : addr_count;
    // Explicit wrap so non-power-of-two SIZE still cycles within 0..SIZE-1.
    assign next_addr     = (cur_addr == LAST_IDX) ? '0 : cur_addr + 1'b1;
    assign handshake     = out_valid && out_ready;
    assign last_entry    = (idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cur_addr   <= '0;
            idx        <= '0;
            remaining  <= '0;
            shadow     <= '0;
            logic_addr <= '0;
            out_addr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        cur_addr  <= start_addr;
                        remaining <= clamped_count;
                        if (clamped_count == '0) begin
                            state <= ST_DONE;
                        end else begin
                            logic_addr <= start_addr;
                            state      <= ST_ADDR;
                        end
                    end
                end
                // logic_addr has been stable for the whole cycle, so the result is settled here.
                ST_ADDR: begin
                    shadow   <= logic_result;
                    out_addr <= cur_addr;
                    idx      <= '0;
                    state    <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (handshake) begin
                        if (!last_entry) begin
                            idx <= idx + 1'b1;
                        end else begin
                            remaining <= remaining - 1'b1;
                            cur_addr  <= next_addr;
                            if (remaining == ONE_CNT) begin
                                state <= ST_DONE;
                            end else begin
                                logic_addr <= next_addr;
                                state      <= ST_ADDR;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign out_valid = (state == ST_STREAM);
    assign out_idx   = idx;
    assign out_data  = shadow[int'(idx) * IW +: IW];
    assign out_last  = out_valid && last_entry && (remaining == ONE_CNT);

endmodule

// File: tb/tb_logic_result_streamer.sv
// Scoreboard bench for logic_result_streamer: a behavioural Logic model feeds
// final_result and every accepted beat is matched against a queue of expected beats.
module tb_logic_result_streamer;

    localparam int SIZE = 16;
    localparam int K    = 8;
    localparam int AW   = 4;
    localparam int IW   = 3;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [AW-1:0] idx;
        logic [IW-1:0] data;
        logic          last;
    } beat_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [AW-1:0]      start_addr;
    logic [AW:0]        addr_count;
    logic               busy;
    logic               done;
    logic [AW-1:0]      logic_addr;
    logic [SIZE*IW-1:0] logic_result;
    logic               out_valid;
    logic               out_ready = 1'b1;
    logic [AW-1:0]      out_addr;
    logic [AW-1:0]      out_idx;
    logic [IW-1:0]      out_data;
    logic               out_last;

    int    compared   = 0;
    int    mismatched = 0;
    int    cycle      = 0;
    int    last_hs_cycle = 0;
    bit    last_hs_valid = 0;
    bit    prev_stall    = 0;
    bit    rand_ready    = 0;
    logic [12:0] held;
    beat_t exp_q[$];
    beat_t exp_beat;

    logic_result_streamer #(.SIZE(SIZE), .K(K)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .start_addr   (start_addr),
        .addr_count   (addr_count),
        .busy         (busy),
        .done         (done),
        .logic_addr   (logic_addr),
        .logic_result (logic_result),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_idx      (out_idx),
        .out_data     (out_data),
        .out_last     (out_last)
    );

    always #5 clk = ~clk;

    // Stand-in for the Logic stage: entry i of the result is (address + i) mod 8.
    always_comb begin
        logic_result = '0;
        for (int i = 0; i < SIZE; i++) begin
            logic_result[i*IW +: IW] = IW'((int'(logic_addr) + i) % K);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, observed, expected, cycle);
        end
    endtask

    // Accepted beats are popped and compared; stalled beats must be unchanged on the next cycle.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            prev_stall    = 0;
            last_hs_valid = 0;
        end else begin
            if (prev_stall)
                checkOutput("stall_hold", {19'd0, out_valid, out_addr, out_idx, out_data, out_last}, {19'd0, held});
            if (done && last_hs_valid) begin
                checkOutput("done_after_last", cycle - last_hs_cycle, 1);
                last_hs_valid = 0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checkOutput("extra_beat", 1, 0);
                end else begin
                    exp_beat = exp_q.pop_front();
                    checkOutput("beat", {20'd0, out_addr, out_idx, out_data, out_last}, {20'd0, exp_beat});
                    if (out_last) begin
                        last_hs_cycle = cycle;
                        last_hs_valid = 1;
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            held       = {out_valid, out_addr, out_idx, out_data, out_last};
        end
    end

    task automatic pushSweep(input int sa, input int cnt);
        int n;
        int a;
        beat_t b;
        n = (cnt > SIZE) ? SIZE : cnt;
        for (int ai = 0; ai < n; ai++) begin
            a = (sa + ai) % SIZE;
            for (int i = 0; i < SIZE; i++) begin
                b.addr = AW'(a);
                b.idx  = AW'(i);
                b.data = IW'((a + i) % K);
                b.last = (ai == n - 1) && (i == SIZE - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic applyStimulus(input int sa, input int cnt);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = AW'(sa);
        addr_count = (AW + 1)'(cnt);
        pushSweep(sa, cnt);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget, input int exp_busy);
        int  n = 0;
        int  busy_cnt = 0;
        bit  seen = 0;
        while (!seen && n < budget) begin
            @(negedge clk);
            n++;
            if (busy) busy_cnt++;
            if (done) seen = 1;
        end
        checkOutput("done_seen", 32'(seen), 1);
        if (seen) begin
            if (exp_busy >= 0)
                checkOutput("busy_cycles", busy_cnt, exp_busy);
            checkOutput("queue_drained", exp_q.size(), 0);
            @(negedge clk);
            checkOutput("done_pulse", {30'd0, done, busy}, 0);
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_valid"}, 32'(out_valid), 0);
        checkOutput({tag, "_last"}, 32'(out_last), 0);
        checkOutput({tag, "_fields"}, {17'd0, logic_addr, out_addr, out_idx, out_data}, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        rst        = 1'b1;
        start      = 1'b0;
        start_addr = '0;
        addr_count = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("[TB] single address, always ready");
        applyStimulus(3, 1);
        waitDone(100, 18);

        $display("[TB] wrap from address 15 to 0");
        applyStimulus(15, 2);
        waitDone(200, 35);

        $display("[TB] random backpressure");
        rand_ready = 1;
        applyStimulus(3, 1);
        waitDone(2000, -1);
        rand_ready = 0;
        repeat (2) @(posedge clk);

        $display("[TB] empty sweep and clamped sweep");
        applyStimulus(6, 0);
        waitDone(10, 1);
        applyStimulus(9, 20);
        waitDone(1000, 273);

        $display("[TB] start during stream is ignored");
        applyStimulus(7, 1);
        repeat (5) @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = 4'd2;
        addr_count = 5'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(100, -1);
        repeat (5) @(negedge clk);
        checkOutput("no_late_beats", {31'd0, busy}, 0);

        $display("[TB] reset mid-stream");
        applyStimulus(5, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(out_valid && out_idx == 4'd7) && n < 100);
        checkOutput("reach_idx7", {31'd0, out_valid}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        checkResetOutputs("midrst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(0, 1);
        waitDone(100, 18);

        $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
